// File: rtl/t03_sprite_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : t03_sprite_rom_arbiter_if
// Purpose  : Bundle of request, grant, ROM and read-return signals between
//            the pixel-source engines, the shared sprite/glyph ROM and the
//            round-robin arbiter.
// Signals  : req[2:0]      level requests (bit0 player 1, bit1 player 2,
//                          bit2 text)
//            addr_p1/p2/txt  request addresses, stable while req bit high
//            freeze        blocks new grants
//            frame_start   one-cycle pulse, resets priority to player 1
//            gnt[2:0]      one-hot combinational grant
//            rom_en/rom_addr registered ROM read port
//            rom_data      ROM read data
//            rdata/rvalid  registered read data with one-hot owner strobe
//            busy          any access in flight
// Modports : master - requesters and ROM side (drives requests, rom_data)
//            slave  - arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface t03_sprite_rom_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic [2:0]        req;
    logic [ADDR_W-1:0] addr_p1;
    logic [ADDR_W-1:0] addr_p2;
    logic [ADDR_W-1:0] addr_txt;
    logic              freeze;
    logic              frame_start;
    logic [2:0]        gnt;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] rdata;
    logic [2:0]        rvalid;
    logic              busy;

    modport master (
        output req, addr_p1, addr_p2, addr_txt, freeze, frame_start, rom_data,
        input  gnt, rom_en, rom_addr, rdata, rvalid, busy
    );

    modport slave (
        input  req, addr_p1, addr_p2, addr_txt, freeze, frame_start, rom_data,
        output gnt, rom_en, rom_addr, rdata, rvalid, busy
    );
endinterface
`default_nettype wire

// File: rtl/t03_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : t03_sprite_rom_arbiter
// Purpose  : Round-robin arbiter sharing one synchronous sprite/glyph ROM
//            port between player 1, player 2 and text glyph fetch. One access
//            is issued per cycle; read data returns in grant order with a
//            one-hot owner strobe, ROM_LAT+2 cycles after the grant.
// Ports    : clk  - system clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - t03_sprite_rom_arbiter_if.slave (requests, grant, ROM
//                   port, read return, busy)
// Params   : ADDR_W  ROM address width
//            DATA_W  ROM data width (RRRGGGBB)
//            ROM_LAT ROM read latency in cycles, legal 1..4
// Revision : 1.0 - initial release
// ============================================================================
module t03_sprite_rom_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    t03_sprite_rom_arbiter_if.slave   bus
);

    localparam logic [1:0] c_SRC_P1  = 2'd0;
    localparam logic [1:0] c_SRC_P2  = 2'd1;
    localparam logic [1:0] c_SRC_TXT = 2'd2;

    // Priority pointer: index of the highest-priority source this cycle.
    logic [1:0]              r_ptr;
    logic                    w_any;
    logic [1:0]              w_gnt_idx;
    logic [1:0]              w_ptr_next;
    logic [5:0]              w_order;
    logic [ADDR_W-1:0]       w_gnt_addr;

    logic                    r_rom_en;
    logic [ADDR_W-1:0]       r_rom_addr;

    // Owner tag pipeline, stage 0 aligned with rom_en, stage ROM_LAT aligned
    // with rom_data. Tags are packed 2 bits per stage, stage 0 in the LSBs.
    logic [ROM_LAT:0]        r_tag_v;
    logic [2*ROM_LAT+1:0]    r_tag;
    logic [1:0]              w_last_tag;

    logic [DATA_W-1:0]       r_rdata;
    logic [2:0]              r_rvalid;

    // ------------------------------------------------------------------
    // Grant selection: scan sources in the order ptr, ptr+1, ptr+2 (mod 3)
    // ------------------------------------------------------------------
    always_comb begin
        // Slot k of the scan order lives in w_order[2k +: 2].
        w_order = {c_SRC_TXT, c_SRC_P2, c_SRC_P1};
        case (r_ptr)
            2'd1:    w_order = {c_SRC_P1,  c_SRC_TXT, c_SRC_P2};
            2'd2:    w_order = {c_SRC_P2,  c_SRC_P1,  c_SRC_TXT};
            default: w_order = {c_SRC_TXT, c_SRC_P2,  c_SRC_P1};
        endcase

        w_any     = 1'b0;
        w_gnt_idx = c_SRC_P1;
        for (int k = 0; k < 3; k++) begin
            if (!w_any && bus.req[w_order[2*k +: 2]]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_order[2*k +: 2];
            end
        end

        // Freeze and reset suppress the grant outright; nothing downstream
        // may see an accepted request in those cycles.
        if (rst || bus.freeze) begin
            w_any = 1'b0;
        end

        w_ptr_next = (w_gnt_idx == c_SRC_TXT) ? c_SRC_P1 : (w_gnt_idx + 2'd1);

        case (w_gnt_idx)
            c_SRC_P2:  w_gnt_addr = bus.addr_p2;
            c_SRC_TXT: w_gnt_addr = bus.addr_txt;
            default:   w_gnt_addr = bus.addr_p1;
        endcase
    end

    assign bus.gnt = w_any ? (3'b001 << w_gnt_idx) : 3'b000;

    // ------------------------------------------------------------------
    // Priority pointer; frame_start wins over a same-cycle grant update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (bus.frame_start) begin
            r_ptr <= 2'd0;
        end else if (w_any) begin
            r_ptr <= w_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // ROM issue stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_rom_en <= w_any;
            if (w_any) begin
                r_rom_addr <= w_gnt_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline and read return
    // ------------------------------------------------------------------
    assign w_last_tag = r_tag[2*ROM_LAT +: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v  <= '0;
            r_tag    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 3'b000;
        end else begin
            r_tag_v <= {r_tag_v[ROM_LAT-1:0], w_any};
            r_tag   <= {r_tag[2*ROM_LAT-1:0], w_gnt_idx};
            if (r_tag_v[ROM_LAT]) begin
                r_rdata  <= bus.rom_data;
                r_rvalid <= 3'b001 << w_last_tag;
            end else begin
                r_rvalid <= 3'b000;
            end
        end
    end

    assign bus.rom_en   = r_rom_en;
    assign bus.rom_addr = r_rom_addr;
    assign bus.rdata    = r_rdata;
    assign bus.rvalid   = r_rvalid;

    // The rvalid stage is still part of the access, so it keeps busy high
    // until the owner strobe has been presented.
    assign bus.busy = r_rom_en | (|r_tag_v) | (|r_rvalid);

endmodule
`default_nettype wire

// File: tb/tb_t03_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_t03_sprite_rom_arbiter
// Purpose  : Directed self-checking bench for t03_sprite_rom_arbiter with a
//            1-cycle ROM model (rom_data = rom_addr[7:0] ^ 8'hA5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_t03_sprite_rom_arbiter;

    localparam int c_ADDR_W = 10;
    localparam int c_DATA_W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    t03_sprite_rom_arbiter_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus ();

    t03_sprite_rom_arbiter #(
        .ADDR_W  (c_ADDR_W),
        .DATA_W  (c_DATA_W),
        .ROM_LAT (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous ROM, one cycle of latency.
    always @(posedge clk) begin
        bus.rom_data <= bus.rom_addr[7:0] ^ 8'hA5;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 3'b000) begin
                failures++;
                $display("FAIL reset_gnt cycle=%0d got=%b exp=000", c, bus.gnt);
            end
            checks++;
            if (bus.rom_en !== 1'b0 || bus.rom_addr !== 10'h000) begin
                failures++;
                $display("FAIL reset_rom cycle=%0d got en=%b addr=%h exp en=0 addr=000", c, bus.rom_en, bus.rom_addr);
            end
            checks++;
            if (bus.rdata !== 8'h00 || bus.rvalid !== 3'b000) begin
                failures++;
                $display("FAIL reset_ret cycle=%0d got rdata=%h rvalid=%b exp 00/000", c, bus.rdata, bus.rvalid);
            end
            checks++;
            if (bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy cycle=%0d got=%b exp=0", c, bus.busy);
            end
            step();
        end
    endtask

    task automatic test_single();
        bus.req     = 3'b001;
        bus.addr_p1 = 10'h012;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b001) begin
            failures++;
            $display("FAIL single_gnt got=%b exp=001", bus.gnt);
        end
        step();
        bus.req = 3'b000;
        @(negedge clk);
        checks++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== 10'h012 || bus.gnt !== 3'b000) begin
            failures++;
            $display("FAIL single_issue got en=%b addr=%h gnt=%b exp en=1 addr=012 gnt=000", bus.rom_en, bus.rom_addr, bus.gnt);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.rom_en !== 1'b0 || bus.busy !== 1'b1 || bus.rvalid !== 3'b000) begin
            failures++;
            $display("FAIL single_mid got en=%b busy=%b rvalid=%b exp en=0 busy=1 rvalid=000", bus.rom_en, bus.busy, bus.rvalid);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 3'b001 || bus.rdata !== 8'hB7 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_ret got rvalid=%b rdata=%h busy=%b exp 001/B7/1", bus.rvalid, bus.rdata, bus.busy);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 3'b000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got rvalid=%b busy=%b exp 000/0", bus.rvalid, bus.busy);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [2:0] seq [3];
        logic [7:0] dat [3];
        logic [2:0] exp_gnt;
        logic [2:0] exp_rv;
        seq = '{3'b001, 3'b010, 3'b100};
        dat = '{8'hA4, 8'hA7, 8'hA6};
        // Return the pointer to player 1 first (previous test left it at 1).
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        bus.addr_p1  = 10'h001;
        bus.addr_p2  = 10'h002;
        bus.addr_txt = 10'h003;
        for (int k = 0; k < 9; k++) begin
            bus.req = (k < 6) ? 3'b111 : 3'b000;
            exp_gnt = (k < 6) ? seq[k % 3] : 3'b000;
            exp_rv  = (k >= 3) ? seq[(k - 3) % 3] : 3'b000;
            @(negedge clk);
            checks++;
            if (bus.gnt !== exp_gnt) begin
                failures++;
                $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", k, bus.gnt, exp_gnt);
            end
            checks++;
            if (bus.rvalid !== exp_rv) begin
                failures++;
                $display("FAIL rr_rvalid cycle=%0d got=%b exp=%b", k, bus.rvalid, exp_rv);
            end
            if (k >= 3) begin
                checks++;
                if (bus.rdata !== dat[(k - 3) % 3]) begin
                    failures++;
                    $display("FAIL rr_rdata cycle=%0d got=%h exp=%h", k, bus.rdata, dat[(k - 3) % 3]);
                end
            end
            step();
        end
    endtask

    task automatic test_frame_start();
        logic [2:0] req_t [6];
        logic       fs_t  [6];
        logic [2:0] gnt_t [6];
        logic [2:0] rv_t  [6];
        logic [7:0] dat_t [6];
        req_t = '{3'b010, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000};
        fs_t  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        gnt_t = '{3'b010, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000};
        rv_t  = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 3'b001};
        dat_t = '{8'h00, 8'h00, 8'h00, 8'hA7, 8'hA6, 8'hA4};
        for (int k = 0; k < 6; k++) begin
            bus.req         = req_t[k];
            bus.frame_start = fs_t[k];
            @(negedge clk);
            checks++;
            if (bus.gnt !== gnt_t[k]) begin
                failures++;
                $display("FAIL fs_gnt cycle=%0d got=%b exp=%b", k, bus.gnt, gnt_t[k]);
            end
            checks++;
            if (bus.rvalid !== rv_t[k]) begin
                failures++;
                $display("FAIL fs_rvalid cycle=%0d got=%b exp=%b", k, bus.rvalid, rv_t[k]);
            end
            if (rv_t[k] != 3'b000) begin
                checks++;
                if (bus.rdata !== dat_t[k]) begin
                    failures++;
                    $display("FAIL fs_rdata cycle=%0d got=%h exp=%h", k, bus.rdata, dat_t[k]);
                end
            end
            step();
        end
        bus.frame_start = 1'b0;
    endtask

    task automatic test_freeze();
        logic [2:0] gnt_t  [10];
        logic       frz_t  [10];
        logic [2:0] rv_t   [10];
        logic       busy_t [10];
        logic [7:0] exp_d;
        gnt_t  = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000,
                   3'b001, 3'b010, 3'b000, 3'b000, 3'b000};
        frz_t  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        rv_t   = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010,
                   3'b000, 3'b000, 3'b000, 3'b001, 3'b010};
        busy_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        bus.addr_p1 = 10'h040;
        bus.addr_p2 = 10'h081;
        for (int k = 0; k < 10; k++) begin
            bus.req    = (k < 7) ? 3'b011 : 3'b000;
            bus.freeze = frz_t[k];
            @(negedge clk);
            checks++;
            if (bus.gnt !== gnt_t[k]) begin
                failures++;
                $display("FAIL frz_gnt cycle=%0d got=%b exp=%b", k, bus.gnt, gnt_t[k]);
            end
            checks++;
            if (bus.rvalid !== rv_t[k]) begin
                failures++;
                $display("FAIL frz_rvalid cycle=%0d got=%b exp=%b", k, bus.rvalid, rv_t[k]);
            end
            checks++;
            if (bus.busy !== busy_t[k]) begin
                failures++;
                $display("FAIL frz_busy cycle=%0d got=%b exp=%b", k, bus.busy, busy_t[k]);
            end
            if (rv_t[k] != 3'b000) begin
                exp_d = (rv_t[k] == 3'b001) ? 8'hE5 : 8'h24;
                checks++;
                if (bus.rdata !== exp_d) begin
                    failures++;
                    $display("FAIL frz_rdata cycle=%0d got=%h exp=%h", k, bus.rdata, exp_d);
                end
            end
            step();
        end
        bus.freeze = 1'b0;
    endtask

    task automatic test_reset_mid();
        // Pointer is at 2 here; player 1 is the only requester.
        bus.req     = 3'b001;
        bus.addr_p1 = 10'h012;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b001) begin
            failures++;
            $display("FAIL rstmid_gnt got=%b exp=001", bus.gnt);
        end
        step();
        rst     = 1'b1;
        bus.req = 3'b111;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b000) begin
            failures++;
            $display("FAIL rstmid_gnt_in_rst got=%b exp=000", bus.gnt);
        end
        step();
        rst     = 1'b0;
        bus.req = 3'b000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.rom_en !== 1'b0 || bus.rom_addr !== 10'h000 || bus.rdata !== 8'h00 ||
                bus.rvalid !== 3'b000 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_state cycle=%0d got en=%b addr=%h rdata=%h rvalid=%b busy=%b exp all 0",
                         c, bus.rom_en, bus.rom_addr, bus.rdata, bus.rvalid, bus.busy);
            end
            step();
        end
        // Pointer must be back at player 1 after reset.
        bus.req = 3'b111;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 3'b001) begin
            failures++;
            $display("FAIL rstmid_ptr got=%b exp=001", bus.gnt);
        end
        step();
        bus.req = 3'b000;
        step();
        step();
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 3'b001 || bus.rdata !== 8'hB7) begin
            failures++;
            $display("FAIL rstmid_ret got rvalid=%b rdata=%h exp 001/B7", bus.rvalid, bus.rdata);
        end
        step();
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        bus.req         = 3'b000;
        bus.addr_p1     = '0;
        bus.addr_p2     = '0;
        bus.addr_txt    = '0;
        bus.freeze      = 1'b0;
        bus.frame_start = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_frame_start();
        test_freeze();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached without completing the sequence");
        $fatal(1);
    end

endmodule
`default_nettype wire
